fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width of each requester's data word and of the FIFO write word.
REQ-002 SHALL provide parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port (2..8).
REQ-003 SHALL provide parameter MAX_BURST, default 8, maximum beats per grant (1..255).
REQ-004 SHALL use a single clock and a synchronous, active-high reset: w_clk  input  1  write-domain clock; all logic on rising edge.
REQ-005 w_rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester word valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed words, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  final word of requester's burst.
REQ-009 req_ready  output  NUM_REQ  word accepted this cycle when valid and ready both high.
REQ-010 fifo_full  input  1  full flag from the FIFO write side.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_w_data  output  DATA_WIDTH  FIFO write data.
REQ-013 grant  output  NUM_REQ  registered one-hot owner of the write port; all-zero when idle.
REQ-014 burst_done  output  1  one-cycle pulse on the final beat of a grant.

Function
REQ-015 SHALL implement two states: IDLE (no owner) and BURST (grant held by one requester).
REQ-016 IDLE: if any req_valid high, SHALL select a winner round-robin, searching upward from rr_ptr and wrapping modulo NUM_REQ; grant register loads the one-hot winner; state goes to BURST next cycle.
REQ-017 IDLE: req_ready, fifo_w_en, and burst_done SHALL be 0; one-cycle arbitration bubble per grant.
REQ-018 BURST: req_ready[i] = grant[i] AND NOT fifo_full; all other req_ready bits 0.
REQ-019 BURST: fifo_w_en = valid of granted requester AND NOT fifo_full; fifo_w_data = granted requester's req_data, combinational from the grant register.
REQ-020 A beat is a cycle with fifo_w_en=1; beat_cnt increments by 1 per beat, is cleared on entry to BURST, and is wide enough for MAX_BURST.
REQ-021 A burst SHALL end on the beat where granted req_last=1 or beat_cnt+1 = MAX_BURST (both together = one end); burst_done=1 that cycle; grant clears and state returns to IDLE next cycle.
REQ-022 On burst end, rr_ptr SHALL load (granted index + 1) mod NUM_REQ.
REQ-023 fifo_full=1 in BURST SHALL stall: no beat, beat_cnt held, grant held, no write issued.
REQ-024 Granted requester dropping req_valid mid-burst SHALL hold grant without counting; no timeout.
REQ-025 Non-granted requesters SHALL be ignored until the next IDLE arbitration.
REQ-026 fifo_w_en SHALL never assert while fifo_full=1; at most one requester ready per cycle.

Reset
REQ-027 w_rst=1 SHALL force state IDLE, grant=0, rr_ptr=0, beat_cnt=0, burst_done=0, fifo_w_en=0, req_ready=0, effective next clock edge.
REQ-028 Reset mid-burst SHALL abandon the burst with no further writes; first arbitration after reset starts at requester 0.

Verification
REQ-029 Reset, req_valid=4'b1111, all last=1, full=0 -> grants 0,1,2,3,0 in order, each 1 beat, burst_done each, IDLE cycle between.
REQ-030 Req 2 alone, 20 words, last=0, MAX_BURST=8 -> 8 writes, burst_done on 8th, IDLE, re-grant to 2, next 8 words.
REQ-031 Req 1 granted, full=1 for 3 cycles mid-burst -> fifo_w_en=0, req_ready=0, beat_cnt frozen; resumes, total beat count unchanged.
REQ-032 Req 0 word with last=1 on the 8th beat (MAX_BURST=8) -> single burst_done, single release, rr_ptr=1.
REQ-033 w_rst=1 during 4th beat of req 3 -> next cycle grant=0, fifo_w_en=0; with req 3 and req 0 valid, first grant goes to 0.
REQ-034 Random valid/last/full, 10k cycles -> fifo_w_data sequence equals per-requester words in order, no write while full, grant always one-hot or zero.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time bursty access
// to a shared FIFO write port, with full back-pressure and burst limit.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                          w_clk,
   input  logic                          w_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          burst_done
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nx;
   logic [NUM_REQ-1:0] grant_nx;
   logic [IW-1:0]     rr_ptr, rr_nx;
   logic [IW-1:0]     gidx, gidx_nx;
   logic [IW-1:0]     win_idx, cand;
   logic              win_found;
   logic [CW-1:0]     beat_cnt, beat_nx;
   logic              cur_valid, cur_last;
   logic              beat, end_beat;

   // Lowest offset from rr_ptr wins, so scan downward and let it overwrite.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign cur_valid   = req_valid[gidx];
   assign cur_last    = req_last[gidx];
   assign fifo_w_data = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

   assign beat     = (state == BURST) && cur_valid && !fifo_full;
   assign end_beat = beat && (cur_last || (beat_cnt + CW'(1) == BURST_MAX));

   always_comb begin
      state_nx   = state;
      grant_nx   = grant;
      gidx_nx    = gidx;
      rr_nx      = rr_ptr;
      beat_nx    = beat_cnt;
      req_ready  = '0;
      fifo_w_en  = 1'b0;
      burst_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_found) begin
               state_nx = BURST;
               grant_nx = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
               gidx_nx  = win_idx;
               beat_nx  = '0;
            end
         end
         BURST: begin
            req_ready = fifo_full ? '0 : grant;
            fifo_w_en = beat;
            if (beat) beat_nx = beat_cnt + CW'(1);
            if (end_beat) begin
               burst_done = 1'b1;
               state_nx   = IDLE;
               grant_nx   = '0;
               rr_nx      = IW'((int'(gidx) + 1) % NUM_REQ);
            end
         end
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state    <= IDLE;
         grant    <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         gidx     <= gidx_nx;
         rr_ptr   <= rr_nx;
         beat_cnt <= beat_nx;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: per-requester word sources, expected-write scoreboard
// and a negedge monitor checking every FIFO write and port invariant.
module tb_fifo_wr_arbiter;

   logic        w_clk = 1'b0;
   logic        w_rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_w_en;
   logic [7:0]  fifo_w_data;
   logic [3:0]  grant;
   logic        burst_done;

   fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_w_en   (fifo_w_en),
      .fifo_w_data (fifo_w_data),
      .grant       (grant),
      .burst_done  (burst_done)
   );

   always #5 w_clk = ~w_clk;

   typedef struct packed {
      logic [1:0] g;
      logic [7:0] d;
      logic       done;
   } exp_t;

   exp_t       exp_q[$];
   int         compared = 0;
   int         fails = 0;
   int         wr_count = 0;
   logic       prev_done = 1'b0;

   logic [7:0] sd [4][64];
   logic       sl [4][64];
   logic [5:0] wp [4];
   logic [5:0] rp [4];
   logic [3:0] hold;
   logic [3:0] hs;

   task automatic push(input int i, input logic [7:0] d, input logic l);
      sd[i][wp[i]] = d;
      sl[i][wp[i]] = l;
      wp[i] = wp[i] + 6'd1;
   endtask

   task automatic ex(input logic [1:0] g, input logic [7:0] d, input logic done);
      exp_t e;
      e.g = g;
      e.d = d;
      e.done = done;
      exp_q.push_back(e);
   endtask

   function automatic logic busy();
      logic b;
      b = 1'b0;
      for (int i = 0; i < 4; i++) if (rp[i] != wp[i]) b = 1'b1;
      return b;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      compared++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy()) && n < 3000) begin
         @(posedge w_clk);
         n++;
      end
      if (n >= 3000) begin
         compared++;
         fails++;
         $display("FAIL drain: timeout, %0d writes still expected", exp_q.size());
      end
      repeat (3) @(posedge w_clk);
   endtask

   task automatic wait_writes(input int target);
      int n;
      n = 0;
      do begin
         @(posedge w_clk);
         #2;
         n++;
      end while (wr_count < target && n < 300);
      if (wr_count < target) begin
         compared++;
         fails++;
         $display("FAIL wait_writes: got %0d writes, expected %0d", wr_count, target);
      end
   endtask

   // Source driver: a handshake seen at negedge is consumed by the next edge.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      hold      = '0;
      for (int i = 0; i < 4; i++) begin
         wp[i] = '0;
         rp[i] = '0;
      end
      forever begin
         @(negedge w_clk);
         hs = req_valid & req_ready;
         @(posedge w_clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (hs[i]) rp[i] = rp[i] + 6'd1;
            req_valid[i]      = (rp[i] != wp[i]) && !hold[i];
            req_data[i*8 +: 8] = sd[i][rp[i]];
            req_last[i]       = sl[i][rp[i]];
         end
      end
   end

   always @(negedge w_clk) begin
      exp_t       e;
      logic [3:0] eg;
      compared++;
      if ($countones(grant) > 1 || (fifo_w_en === 1'b1 && fifo_full === 1'b1)) begin
         fails++;
         $display("FAIL invariant: grant=%b w_en=%b full=%b", grant, fifo_w_en, fifo_full);
      end
      compared++;
      if (req_ready !== (fifo_full ? 4'b0000 : grant)) begin
         fails++;
         $display("FAIL ready: got %b, expected %b", req_ready, fifo_full ? 4'b0000 : grant);
      end
      if (prev_done) begin
         compared++;
         if (grant !== 4'b0000 || fifo_w_en !== 1'b0) begin
            fails++;
            $display("FAIL bubble: grant=%b w_en=%b, expected 0000/0", grant, fifo_w_en);
         end
      end
      if (fifo_w_en === 1'b1) begin
         wr_count++;
         compared++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL write: unexpected write grant=%b data=%h", grant, fifo_w_data);
         end else begin
            e  = exp_q.pop_front();
            eg = 4'b0001 << e.g;
            if ({grant, fifo_w_data, burst_done} !== {eg, e.d, e.done}) begin
               fails++;
               $display("FAIL write: got grant=%b data=%h done=%b, expected grant=%b data=%h done=%b",
                        grant, fifo_w_data, burst_done, eg, e.d, e.done);
            end
         end
      end else begin
         compared++;
         if (burst_done !== 1'b0) begin
            fails++;
            $display("FAIL done: burst_done=%b without a write", burst_done);
         end
      end
      prev_done = (burst_done === 1'b1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      w_rst     = 1'b1;
      fifo_full = 1'b0;
      #1;

      // All four requesters single-beat, plus a second word on 0.
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      push(0, 8'h20, 1'b1);
      ex(0, 8'h10, 1); ex(1, 8'h11, 1); ex(2, 8'h12, 1);
      ex(3, 8'h13, 1); ex(0, 8'h20, 1);
      repeat (3) @(posedge w_clk);
      @(negedge w_clk);
      chk("reset_grant", 8'(grant), 8'h0);
      chk("reset_w_en", 8'(fifo_w_en), 8'h0);
      chk("reset_ready", 8'(req_ready), 8'h0);
      chk("reset_done", 8'(burst_done), 8'h0);
      @(posedge w_clk);
      #1 w_rst = 1'b0;
      drain();

      // Requester 2 alone: bursts cut at 8 beats.
      for (int k = 0; k < 20; k++) begin
         push(2, 8'h40 + 8'(k), k == 19);
         ex(2, 8'h40 + 8'(k), k == 7 || k == 15 || k == 19);
      end
      drain();

      // Requester 1 stalled by full for 3 cycles after 2 beats.
      base = wr_count;
      for (int k = 0; k < 10; k++) begin
         push(1, 8'h60 + 8'(k), k == 9);
         ex(1, 8'h60 + 8'(k), k == 7 || k == 9);
      end
      wait_writes(base + 2);
      fifo_full = 1'b1;
      repeat (3) @(posedge w_clk);
      #2 fifo_full = 1'b0;
      drain();

      // last on the 8th beat gives one release; rr_ptr then favours 1.
      for (int k = 0; k < 8; k++) begin
         push(0, 8'h80 + 8'(k), k == 7);
         ex(0, 8'h80 + 8'(k), k == 7);
      end
      drain();
      push(0, 8'hA0, 1'b1);
      push(1, 8'hA1, 1'b1);
      ex(1, 8'hA1, 1);
      ex(0, 8'hA0, 1);
      drain();

      // Reset during requester 3's 4th beat.
      base = wr_count;
      for (int k = 0; k < 6; k++) push(3, 8'hC0 + 8'(k), k == 5);
      ex(3, 8'hC0, 0); ex(3, 8'hC1, 0); ex(3, 8'hC2, 0); ex(3, 8'hC3, 0);
      ex(0, 8'h90, 1); ex(3, 8'hC4, 0); ex(3, 8'hC5, 1);
      wait_writes(base + 3);
      w_rst = 1'b1;
      push(0, 8'h90, 1'b1);
      @(posedge w_clk);
      #1 w_rst = 1'b0;
      @(negedge w_clk);
      chk("rst_mid_grant", 8'(grant), 8'h0);
      chk("rst_mid_w_en", 8'(fifo_w_en), 8'h0);
      drain();

      // Granted requester drops valid; waiting requester must not steal.
      base = wr_count;
      push(2, 8'hD0, 1'b0); push(2, 8'hD1, 1'b0); push(2, 8'hD2, 1'b1);
      ex(2, 8'hD0, 0); ex(2, 8'hD1, 0); ex(2, 8'hD2, 1); ex(1, 8'hE0, 1);
      wait_writes(base + 1);
      hold[2] = 1'b1;
      push(1, 8'hE0, 1'b1);
      repeat (3) @(posedge w_clk);
      #2 hold[2] = 1'b0;
      drain();

      chk("leftover_expected", 8'(exp_q.size()), 8'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
      $finish;
   end

endmodule
